// File: rtl/vc_mem_arb_pkg.sv
// rtl/vc_mem_arb_pkg.sv - shared constants and helpers for the 3:1 memory arbiter
package vc_mem_arb_pkg;

    localparam int c_num_ports = 3;
    localparam int c_id_sz     = 2;

    typedef logic [c_id_sz-1:0] port_id_t;

    localparam port_id_t c_port0 = 2'd0;
    localparam port_id_t c_port1 = 2'd1;
    localparam port_id_t c_port2 = 2'd2;

    // Request layout {type, addr, len, data}; response layout {type, len, data}
    function automatic int mem_req_msg_sz(input int addr_sz, input int data_sz);
        return 1 + addr_sz + $clog2(data_sz / 8) + data_sz;
    endfunction

    function automatic int mem_resp_msg_sz(input int data_sz);
        return 1 + $clog2(data_sz / 8) + data_sz;
    endfunction

    function automatic port_id_t next_port(input port_id_t p);
        return (p >= c_port2) ? c_port0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/vc_mem_arb_owner_fifo.sv
// rtl/vc_mem_arb_owner_fifo.sv - in-order FIFO of grant owner IDs
module vc_mem_arb_owner_fifo #(
    parameter  int p_depth  = 4,
    parameter  int p_width  = 2,
    localparam int c_ptr_sz = $clog2(p_depth),
    localparam int c_cnt_sz = c_ptr_sz + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic [p_width-1:0]  push_data,
    input  logic                pop,
    output logic [p_width-1:0]  pop_data,
    output logic                full,
    output logic                empty,
    output logic [c_cnt_sz-1:0] count
);

    logic [p_width-1:0]  mem [p_depth];
    logic [c_ptr_sz-1:0] wr_ptr;
    logic [c_ptr_sz-1:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign full     = (count == c_cnt_sz'(p_depth));
    assign empty    = (count == '0);
    // No bypass: a full FIFO refuses a push even if the head leaves this cycle
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + c_ptr_sz'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + c_ptr_sz'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + c_cnt_sz'(1);
                2'b01:   count <= count - c_cnt_sz'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vc_mem_arb_3to1.sv
// rtl/vc_mem_arb_3to1.sv - round-robin arbiter sharing one val/rdy memory among three requesters
module vc_mem_arb_3to1
    import vc_mem_arb_pkg::*;
#(
    parameter  int p_addr_sz     = 8,
    parameter  int p_data_sz     = 32,
    parameter  int p_max_outst   = 4,
    localparam int c_req_msg_sz  = mem_req_msg_sz(p_addr_sz, p_data_sz),
    localparam int c_resp_msg_sz = mem_resp_msg_sz(p_data_sz),
    localparam int c_cnt_sz      = $clog2(p_max_outst) + 1
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     req0_val,
    output logic                     req0_rdy,
    input  logic [c_req_msg_sz-1:0]  req0_msg,
    input  logic                     req1_val,
    output logic                     req1_rdy,
    input  logic [c_req_msg_sz-1:0]  req1_msg,
    input  logic                     req2_val,
    output logic                     req2_rdy,
    input  logic [c_req_msg_sz-1:0]  req2_msg,

    output logic                     resp0_val,
    input  logic                     resp0_rdy,
    output logic [c_resp_msg_sz-1:0] resp0_msg,
    output logic                     resp1_val,
    input  logic                     resp1_rdy,
    output logic [c_resp_msg_sz-1:0] resp1_msg,
    output logic                     resp2_val,
    input  logic                     resp2_rdy,
    output logic [c_resp_msg_sz-1:0] resp2_msg,

    output logic                     memreq_val,
    input  logic                     memreq_rdy,
    output logic [c_req_msg_sz-1:0]  memreq_msg,

    input  logic                     memresp_val,
    output logic                     memresp_rdy,
    input  logic [c_resp_msg_sz-1:0] memresp_msg,

    output logic [c_cnt_sz-1:0]      outst_count
);

    port_id_t   prio;
    port_id_t   prio_eff;
    port_id_t   cand1;
    port_id_t   cand2;
    port_id_t   grant_id;
    port_id_t   owner;
    logic       any_val;
    logic [2:0] grant;
    logic [2:0] req_val_a;
    logic [2:0] resp_rdy_a;
    logic       owner_rdy;
    logic       can_issue;
    logic       fire;
    logic       resp_fire;
    logic       fifo_full;
    logic       fifo_empty;

    assign req_val_a  = {req2_val, req1_val, req0_val};
    assign resp_rdy_a = {resp2_rdy, resp1_rdy, resp0_rdy};

    // An illegal pointer value of 3 is searched as if it were port 0
    assign prio_eff = (prio == 2'd3) ? c_port0 : prio;
    assign cand1    = next_port(prio_eff);
    assign cand2    = next_port(cand1);

    always_comb begin
        grant    = 3'b000;
        grant_id = c_port0;
        any_val  = 1'b0;
        if (req_val_a[prio_eff]) begin
            grant_id = prio_eff;
            any_val  = 1'b1;
        end else if (req_val_a[cand1]) begin
            grant_id = cand1;
            any_val  = 1'b1;
        end else if (req_val_a[cand2]) begin
            grant_id = cand2;
            any_val  = 1'b1;
        end
        if (any_val) begin
            grant[grant_id] = 1'b1;
        end
    end

    always_comb begin
        case (grant_id)
            c_port1: memreq_msg = req1_msg;
            c_port2: memreq_msg = req2_msg;
            default: memreq_msg = req0_msg;
        endcase
    end

    assign can_issue  = !fifo_full;
    assign memreq_val = reset && can_issue && any_val;
    assign fire       = memreq_val && memreq_rdy;

    assign req0_rdy = reset && grant[0] && can_issue && memreq_rdy;
    assign req1_rdy = reset && grant[1] && can_issue && memreq_rdy;
    assign req2_rdy = reset && grant[2] && can_issue && memreq_rdy;

    always_comb begin
        case (owner)
            c_port1: owner_rdy = resp_rdy_a[1];
            c_port2: owner_rdy = resp_rdy_a[2];
            default: owner_rdy = resp_rdy_a[0];
        endcase
    end

    assign memresp_rdy = reset && !fifo_empty && owner_rdy;
    assign resp_fire   = memresp_val && memresp_rdy;

    assign resp0_val = reset && memresp_val && !fifo_empty && (owner == c_port0);
    assign resp1_val = reset && memresp_val && !fifo_empty && (owner == c_port1);
    assign resp2_val = reset && memresp_val && !fifo_empty && (owner == c_port2);
    assign resp0_msg = memresp_msg;
    assign resp1_msg = memresp_msg;
    assign resp2_msg = memresp_msg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio <= c_port0;
        end else if (fire) begin
            prio <= next_port(grant_id);
        end
    end

    vc_mem_arb_owner_fifo #(
        .p_depth (p_max_outst),
        .p_width (c_id_sz)
    ) owner_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fire),
        .push_data (grant_id),
        .pop       (resp_fire),
        .pop_data  (owner),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (outst_count)
    );

    // A response with nobody waiting for it means the memory and arbiter disagree
    assert property (@(posedge clk) disable iff (!reset) !(memresp_val && fifo_empty));
    assert property (@(posedge clk) disable iff (!reset) prio != 2'd3);

endmodule

// File: tb/tb_vc_mem_arb_3to1.sv
// tb/tb_vc_mem_arb_3to1.sv - scoreboard bench for the 3:1 memory arbiter
module tb_vc_mem_arb_3to1;

    localparam int DEPTH = 4;
    localparam int RQ    = 43;
    localparam int RS    = 35;

    typedef struct {
        logic [RS-1:0] msg;
        int            t;
    } mresp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [2:0]    req_val;
    logic [2:0]    req_rdy_w;
    logic [RQ-1:0] req_msg [3];
    logic [2:0]    resp_val_w;
    logic [2:0]    resp_rdy;
    logic [RS-1:0] resp_msg_w [3];
    logic          memreq_val;
    logic          memreq_rdy;
    logic [RQ-1:0] memreq_msg;
    logic          memresp_val;
    logic          memresp_rdy;
    logic [RS-1:0] memresp_msg;
    logic [2:0]    outst_count;

    mresp_t        mq[$];
    logic [RQ-1:0] req_q[3][$];
    logic [RS-1:0] exp_q[3][$];
    int            own_q[$];
    int            grant_log[$];
    logic [31:0]   mem_arr [256];
    logic [31:0]   ref_mem [256];
    bit            hold [3];
    bit            cont, f_rr, f_mr, mr_val;
    logic [2:0]    rr_val;
    int            last_g, lat_max, cyc, last_t, nfires;
    int            resp_cnt [3];
    logic [RS-1:0] last_resp [3];
    int            ncmp, nerr;

    vc_mem_arb_3to1 dut (
        .clk         (clk),
        .reset       (reset),
        .req0_val    (req_val[0]),
        .req0_rdy    (req_rdy_w[0]),
        .req0_msg    (req_msg[0]),
        .req1_val    (req_val[1]),
        .req1_rdy    (req_rdy_w[1]),
        .req1_msg    (req_msg[1]),
        .req2_val    (req_val[2]),
        .req2_rdy    (req_rdy_w[2]),
        .req2_msg    (req_msg[2]),
        .resp0_val   (resp_val_w[0]),
        .resp0_rdy   (resp_rdy[0]),
        .resp0_msg   (resp_msg_w[0]),
        .resp1_val   (resp_val_w[1]),
        .resp1_rdy   (resp_rdy[1]),
        .resp1_msg   (resp_msg_w[1]),
        .resp2_val   (resp_val_w[2]),
        .resp2_rdy   (resp_rdy[2]),
        .resp2_msg   (resp_msg_w[2]),
        .memreq_val  (memreq_val),
        .memreq_rdy  (memreq_rdy),
        .memreq_msg  (memreq_msg),
        .memresp_val (memresp_val),
        .memresp_rdy (memresp_rdy),
        .memresp_msg (memresp_msg),
        .outst_count (outst_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        ncmp++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic logic [RQ-1:0] mk(input bit t, input int a, input logic [31:0] d);
        return {t, a[7:0], 2'b00, d};
    endfunction

    function automatic logic [RS-1:0] exec(input logic [RQ-1:0] m, input logic [31:0] old);
        if (m[42]) return {1'b1, m[33:32], 32'h0};
        return {1'b0, m[33:32], old};
    endfunction

    // Environment: memory model, reference arbiter, scoreboard producer
    always @(negedge clk) begin
        int eg, cnt, hd, p, t;
        mresp_t e;
        if (!reset) begin
            own_q.delete();
            mq.delete();
            for (int n = 0; n < 3; n++) exp_q[n].delete();
            last_g = 2;
            last_t = 0;
        end else begin
            eg = -1;
            for (int k = 1; k <= 3; k++) begin
                p = (last_g + k) % 3;
                if (eg < 0 && req_val[p]) eg = p;
            end
            cnt = own_q.size();
            hd  = (cnt > 0) ? own_q[0] : -1;
            chk("memreq_val", memreq_val, cnt < DEPTH && eg >= 0);
            for (int n = 0; n < 3; n++)
                chk($sformatf("req%0d_rdy", n), req_rdy_w[n], n == eg && cnt < DEPTH && memreq_rdy);
            if (eg >= 0 && cnt < DEPTH) chk("memreq_msg", memreq_msg, req_msg[eg]);
            chk("outst_count", outst_count, cnt);
            for (int n = 0; n < 3; n++)
                chk($sformatf("resp%0d_val", n), resp_val_w[n], memresp_val && hd == n);
            chk("memresp_rdy", memresp_rdy, hd >= 0 && resp_rdy[hd]);

            if (memresp_val && memresp_rdy) begin
                if (own_q.size() > 0) void'(own_q.pop_front());
                if (mq.size() > 0) void'(mq.pop_front());
            end
            for (int n = 0; n < 3; n++) begin
                if (req_val[n] && req_rdy_w[n]) begin
                    nfires++;
                    grant_log.push_back(n);
                    own_q.push_back(n);
                    last_g = n;
                    exp_q[n].push_back(exec(req_msg[n], ref_mem[req_msg[n][41:34]]));
                    if (req_msg[n][42]) ref_mem[req_msg[n][41:34]] = req_msg[n][31:0];
                    hold[n] = 1'b0;
                    if (req_q[n].size() > 0) void'(req_q[n].pop_front());
                end
            end
            if (memreq_val && memreq_rdy) begin
                e.msg = exec(memreq_msg, mem_arr[memreq_msg[41:34]]);
                if (memreq_msg[42]) mem_arr[memreq_msg[41:34]] = memreq_msg[31:0];
                t = cyc + $urandom_range(1, lat_max);
                if (t < last_t) t = last_t;
                last_t = t;
                e.t = t;
                mq.push_back(e);
            end
        end
    end

    // Monitor: consumes expected responses as the DUT delivers them
    always @(negedge clk) begin
        if (reset) begin
            for (int n = 0; n < 3; n++) begin
                if (resp_val_w[n] && resp_rdy[n]) begin
                    resp_cnt[n]++;
                    last_resp[n] = resp_msg_w[n];
                    if (exp_q[n].size() == 0) begin
                        ncmp++;
                        nerr++;
                        $display("FAIL resp%0d_unexpected: actual=%0h required=none", n, resp_msg_w[n]);
                    end else begin
                        chk($sformatf("resp%0d_msg", n), resp_msg_w[n], exp_q[n].pop_front());
                    end
                end
            end
        end
    end

    task automatic drive();
        for (int n = 0; n < 3; n++) begin
            if (!hold[n]) hold[n] = (req_q[n].size() > 0) && (cont || $urandom_range(0, 1) == 1);
            req_val[n] = hold[n];
            req_msg[n] = (req_q[n].size() > 0) ? req_q[n][0] : RQ'({$urandom(), $urandom()});
            resp_rdy[n] = f_rr ? rr_val[n] : ($urandom_range(0, 3) != 0);
        end
        memreq_rdy = f_mr ? mr_val : ($urandom_range(0, 3) != 0);
        if (mq.size() > 0 && mq[0].t <= cyc) begin
            memresp_val = 1'b1;
            memresp_msg = mq[0].msg;
        end else begin
            memresp_val = 1'b0;
            memresp_msg = RS'({$urandom(), $urandom()});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        #1;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            done = own_q.size() == 0 && mq.size() == 0 && !hold[0] && !hold[1] && !hold[2]
                && req_q[0].size() == 0 && req_q[1].size() == 0 && req_q[2].size() == 0;
            if (!done) step();
        end
        chk("drain_done", done, 1);
    endtask

    task automatic chk_gated(input string tag);
        chk({tag, "_memreq_val"}, memreq_val, 0);
        chk({tag, "_req_rdy"}, req_rdy_w, 0);
        chk({tag, "_resp_val"}, resp_val_w, 0);
        chk({tag, "_memresp_rdy"}, memresp_rdy, 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int f, rc0, rc1, rc2;
        bit found;
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        ncmp = 0; nerr = 0; cyc = 0; nfires = 0; last_g = 2; last_t = 0;
        cont = 1; f_rr = 1; rr_val = 3'b111; f_mr = 1; mr_val = 1; lat_max = 1;
        req_val = '0; resp_rdy = '0; memreq_rdy = 0; memresp_val = 0; memresp_msg = '0;
        for (int n = 0; n < 3; n++) begin
            req_msg[n] = '0; hold[n] = 0; resp_cnt[n] = 0; last_resp[n] = '0;
            for (int k = 0; k < 2; k++) req_q[n].push_back(mk(1, 16'h40 + n * 2 + k, $urandom()));
        end

        // Reset: all requesters valid, outputs must stay gated
        drive();
        step();
        step();
        chk_gated("reset");
        chk("reset_outst_count", outst_count, 0);

        // All three continuously valid from reset
        @(posedge clk);
        #1;
        reset = 1;
        drive();
        @(negedge clk);
        #1;
        drain();
        chk("grant_log_size", grant_log.size(), 6);
        for (int k = 0; k < 6 && k < grant_log.size(); k++)
            chk($sformatf("grant_order_%0d", k), grant_log[k], k % 3);

        // Port1 writes then reads 0x10
        rc0 = resp_cnt[0]; rc1 = resp_cnt[1]; rc2 = resp_cnt[2];
        req_q[1].push_back(mk(1, 8'h10, 32'hdeadbeef));
        req_q[1].push_back(mk(0, 8'h10, 32'h0));
        drain();
        chk("p1_resp_count", resp_cnt[1], rc1 + 2);
        chk("p1_read_data", last_resp[1], {1'b0, 2'b00, 32'hdeadbeef});
        chk("p0_no_resp", resp_cnt[0], rc0);
        chk("p2_no_resp", resp_cnt[2], rc2);

        // FIFO full with port0 responses held back
        rr_val = 3'b000;
        for (int k = 0; k < 6; k++) req_q[0].push_back(mk(0, k, 32'h0));
        repeat (10) step();
        chk("full_outst_count", outst_count, 4);
        chk("full_memreq_val", memreq_val, 0);
        chk("full_req_rdy", req_rdy_w, 0);
        f = nfires;
        rr_val = 3'b001;
        step();
        rr_val = 3'b000;
        repeat (5) step();
        chk("full_one_more_fire", nfires, f + 1);
        chk("full_refill_count", outst_count, 4);
        f_rr = 0;
        drain();

        // Response backpressure on port2
        f_rr = 1; rr_val = 3'b000;
        req_q[2].push_back(mk(0, 8'h10, 32'h0));
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = memresp_val && resp_val_w[2];
        end
        chk("bp_resp_seen", found, 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_memresp_rdy", memresp_rdy, 0);
            chk("bp_outst_count", outst_count, 1);
            if (i < 4) step();
        end
        rr_val = 3'b100;
        step();
        chk("bp_release_val", resp_val_w[2], 1);
        chk("bp_release_rdy", memresp_rdy, 1);
        rr_val = 3'b000;
        step();
        chk("bp_after_count", outst_count, 0);

        // Simultaneous push and pop at occupancy 2
        req_q[0].push_back(mk(0, 8'h10, 32'h0));
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            found = outst_count == 1;
        end
        req_q[1].push_back(mk(1, 8'h20, 32'h13572468));
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            found = outst_count == 2 && memresp_val;
        end
        chk("pp_occupancy2", found, 1);
        req_q[2].push_back(mk(0, 8'h20, 32'h0));
        rr_val = 3'b001;
        step();
        chk("pp_push", memreq_val && memreq_rdy, 1);
        chk("pp_pop", memresp_val && memresp_rdy, 1);
        chk("pp_resp_val", resp_val_w, 3'b001);
        rr_val = 3'b000;
        step();
        chk("pp_outst_count", outst_count, 2);
        f_rr = 0;
        drain();

        // Reset with three requests in flight
        f_rr = 1; rr_val = 3'b000;
        for (int n = 0; n < 3; n++) req_q[n].push_back(mk(0, n, 32'h0));
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = outst_count == 3;
        end
        chk("rst_outst3", found, 1);
        @(posedge clk);
        #3;
        reset = 0;
        #1;
        chk_gated("rst_async");
        @(negedge clk);
        #1;
        chk("rst_outst_count", outst_count, 0);
        for (int n = 0; n < 3; n++) req_q[n].push_back(mk(1, 8'h30 + n, $urandom()));
        step();
        grant_log.delete();
        @(posedge clk);
        #1;
        reset = 1;
        drive();
        @(negedge clk);
        #1;
        chk("rst_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);
        f_rr = 0;
        drain();

        // Randomized traffic
        cont = 0; f_rr = 0; f_mr = 0; lat_max = 3;
        for (int i = 0; i < 1500; i++) begin
            for (int n = 0; n < 3; n++)
                if ($urandom_range(0, 7) == 0 && req_q[n].size() < 4)
                    req_q[n].push_back(mk($urandom_range(0, 1), $urandom_range(0, 15), $urandom()));
            step();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/vc_mem_arb_3to1.md
# vc_mem_arb_3to1

Round-robin arbiter that shares one single-ported val/rdy memory between three requesters (e.g. instruction fetch, data port, accelerator). Requests are muxed combinationally onto the memory request port. Each grant's owner ID is recorded in an in-order owner FIFO, and each memory response is routed back to the requester that issued it. It sits between the three clients and a single memory, or the port of a cache.

## Interface
- p_addr_sz, 8, mem message address width in bits
- p_data_sz, 32, mem message data width in bits
- p_max_outst, 4, max in-flight requests (owner FIFO depth, power of 2, ≥2)
- c_req_msg_sz / c_resp_msg_sz, derived from `VC_MEM_REQ_MSG_SZ(p_addr_sz,p_data_sz)` / `VC_MEM_RESP_MSG_SZ(p_data_sz)`, not set externally

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- req{0,1,2}_val / req{0,1,2}_rdy / req{0,1,2}_msg  in/out/in  1/1/c_req_msg_sz  requester request channels
- resp{0,1,2}_val / resp{0,1,2}_rdy / resp{0,1,2}_msg  out/in/out  1/1/c_resp_msg_sz  requester response channels
- memreq_val / memreq_rdy / memreq_msg  out/in/out  1/1/c_req_msg_sz  to memory
- memresp_val / memresp_rdy / memresp_msg  in/out/in  1/1/c_resp_msg_sz  from memory
- outst_count  out  $clog2(p_max_outst)+1  current number of in-flight requests

## Operation
- State: 2-bit round-robin pointer `prio` (highest-priority port), owner FIFO (2-bit IDs), occupancy count.
- Grant: search ports prio, prio+1, prio+2 (mod 3), and select the first port with reqN_val. At most one grant is active.
- `can_issue` = !fifo_full. memreq_val = can_issue && (any reqN_val). memreq_msg = msg of the granted port; it is a don't-care when no grant.
- reqN_rdy = grantN && can_issue && memreq_rdy. A port that is not granted sees rdy=0.
- Request fire (memreq_val && memreq_rdy):
  - push the granted ID to the FIFO;
  - set prio = (granted+1) mod 3.
  - With no fire, prio is held.
- Response routing: owner = FIFO head.
  - respN_val = memresp_val && !fifo_empty && owner==N.
  - respN_msg = memresp_msg, broadcast to all ports; it is qualified by val.
  - memresp_rdy = !fifo_empty && resp<owner>_rdy.
- Response fire pops the head.
- Push and pop in the same cycle: occupancy is unchanged. When the FIFO is full, push is blocked even if a pop fires in that cycle (no full bypass).
- memresp_val while the FIFO is empty is a protocol error: memresp_rdy=0, and `VC_ASSERT` fires.
- Message contents are never modified; the memory is assumed to respond in order.
- The prio pointer never holds 3. If it does, it is treated as 0 and the assertion fires.

## Timing
- Request path is combinational with 0 added cycles. Response path is combinational with 0 added cycles. Total round-trip latency equals the memory latency.
- Reset (async, on reset=0): prio=0, FIFO empty, outst_count=0. While in reset: respN_val=0, memresp_rdy=0, reqN_rdy=0, memreq_val=0, with all outputs gated by reset.
- Reset asserted mid-transaction drops in-flight ownership. Responses that arrive after reset deasserts with an empty FIFO are errors. The environment must drain or reset the memory together with this block.
- Fairness: a continuously-valid port is granted within 3 request fires.
- outst_count is registered and updates on the posedge after a fire.

## Structure
- Package `vc_mem_arb_pkg`: port-ID constants (c_port0..2, c_num_ports=3) and an ID width of 2.
- Sub-module `vc_mem_arb_owner_fifo`: parameterized-depth sync FIFO with async active-low reset, full/empty flags and a count output.
- The round-robin grant logic stays inline as a small combinational always block.

## Test plan
- Single requester, back-to-back: port1 writes 0xdeadbeef to addr 0x10, then reads it. Required: port1 receives a write response then a read response with data 0xdeadbeef, and ports 0 and 2 see no resp_val.
- All three ports continuously valid from reset: grant order 0,1,2,0,1,2. Each response must return to the issuing port in that order.
- FIFO full: memresp_rdy withheld by holding resp0_rdy=0 with p_max_outst=4. After 4 fires, memreq_val=0 and all reqN_rdy=0, with outst_count=4. Releasing one response allows exactly one new fire.
- Response backpressure: owner=port2 with resp2_rdy=0 for 5 cycles. memresp_rdy must be 0 for those cycles, and no pop occurs. The response is delivered on the first cycle resp2_rdy=1.
- Reset mid-operation: assert reset with 3 requests outstanding. Outputs go to reset values immediately (async), and outst_count reads 0 at the next sample. After release, the first grant goes to port 0.
- Simultaneous push and pop at occupancy 2: outst_count stays 2, and both the new owner ID and the response routing are correct.
